// File: rtl/line_engine_pkg.sv
// Shared definitions for the line engine: FSM encoding, geometry defaults and the
// CPU-side register map used by the MMIO decoder that drives the strobes.
package line_engine_pkg;

  localparam int          LE_COORD_W = 10;
  localparam logic [31:0] LE_FB_BASE = 32'h1000_0000;

  // Byte offsets of the strobe registers inside the CPU's line-engine window
  localparam logic [7:0] LE_MMIO_X0      = 8'h00;
  localparam logic [7:0] LE_MMIO_Y0      = 8'h04;
  localparam logic [7:0] LE_MMIO_X1      = 8'h08;
  localparam logic [7:0] LE_MMIO_Y1      = 8'h0C;
  localparam logic [7:0] LE_MMIO_COLOR   = 8'h10;
  localparam logic [7:0] LE_MMIO_TRIGGER = 8'h14;

  typedef enum logic [1:0] {
    LE_IDLE = 2'd0,
    LE_SWAP = 2'd1,
    LE_INIT = 2'd2,
    LE_DRAW = 2'd3
  } le_state_t;

endpackage

// File: rtl/line_engine_if.sv
// Frame-buffer pixel write port of the line engine.
// Handshake: a write transfers on a clock edge where px_valid && px_ready; once px_valid
// rises, px_addr/px_data hold and px_valid stays high until that edge.
interface line_engine_if
  import line_engine_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              px_valid;
  logic              px_ready;
  logic [ADDR_W-1:0] px_addr;
  logic [DATA_W-1:0] px_data;

  modport master (output px_valid, output px_addr, output px_data, input px_ready);
  modport slave  (input px_valid, input px_addr, input px_data, output px_ready);
endinterface

// File: rtl/line_engine.sv
// Bresenham line rasteriser: latches endpoints/colour from CPU strobes and emits one
// frame-buffer write per visible pixel over the px_* port.
module line_engine
  import line_engine_pkg::*;
#(
  parameter int          COORD_W  = LE_COORD_W,
  parameter int          SCREEN_W = 800,
  parameter int          SCREEN_H = 600,
  parameter logic [31:0] FB_BASE  = LE_FB_BASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] line_point,
  input  logic [31:0]        line_color,
  input  logic               line_color_valid,
  input  logic               line_x0_valid,
  input  logic               line_y0_valid,
  input  logic               line_x1_valid,
  input  logic               line_y1_valid,
  input  logic               line_trigger,
  output logic               line_ready,
  line_engine_if.master      px,
  output le_state_t          state_dbg
);

  localparam logic [COORD_W:0] SCR_W = SCREEN_W[COORD_W:0];
  localparam logic [COORD_W:0] SCR_H = SCREEN_H[COORD_W:0];

  le_state_t state, state_n;

  logic [COORD_W-1:0] x0_r, y0_r, x1_r, y1_r;
  logic [23:0]        color_r;

  // Endpoints after steep/direction normalisation, plus the walking point
  logic               steep_r, ydown_r;
  logic [COORD_W-1:0] wx0_r, wy0_r, wx1_r, wy1_r;
  logic [COORD_W-1:0] x_r, y_r, dx_r, dy_r;
  logic signed [COORD_W+1:0] err_r, err_sub;

  logic [COORD_W-1:0] adx, ady, sx0, sy0, sx1, sy1;
  logic               steep_c;
  logic [COORD_W-1:0] pix_x, pix_y;
  logic               is_draw, visible, step, last;

  always_comb begin
    adx     = (x1_r >= x0_r) ? x1_r - x0_r : x0_r - x1_r;
    ady     = (y1_r >= y0_r) ? y1_r - y0_r : y0_r - y1_r;
    steep_c = ady > adx;
    sx0     = steep_c ? y0_r : x0_r;
    sy0     = steep_c ? x0_r : y0_r;
    sx1     = steep_c ? y1_r : x1_r;
    sy1     = steep_c ? x1_r : y1_r;
  end

  always_comb begin
    pix_x   = steep_r ? y_r : x_r;
    pix_y   = steep_r ? x_r : y_r;
    is_draw = (state == LE_DRAW);
    visible = ({1'b0, pix_x} < SCR_W) && ({1'b0, pix_y} < SCR_H);
    // Off-screen pixels advance without waiting for the frame buffer
    step    = is_draw && (!visible || px.px_ready);
    last    = (x_r == wx1_r);
    err_sub = err_r - $signed({2'b00, dy_r});
  end

  assign px.px_valid = is_draw && visible;
  assign px.px_addr  = is_draw ? FB_BASE + 32'({pix_y, pix_x, 2'b00}) : '0;
  assign px.px_data  = is_draw ? {8'h00, color_r} : '0;
  assign state_dbg   = state;

  always_comb begin
    state_n = state;
    case (state)
      LE_IDLE: if (line_ready && line_trigger) state_n = LE_SWAP;
      LE_SWAP: state_n = LE_INIT;
      LE_INIT: state_n = LE_DRAW;
      LE_DRAW: if (step && last) state_n = LE_IDLE;
      default: state_n = LE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LE_IDLE;
      line_ready <= 1'b1;
      x0_r <= '0; y0_r <= '0; x1_r <= '0; y1_r <= '0; color_r <= '0;
      steep_r <= 1'b0; ydown_r <= 1'b0;
      wx0_r <= '0; wy0_r <= '0; wx1_r <= '0; wy1_r <= '0;
      x_r <= '0; y_r <= '0; dx_r <= '0; dy_r <= '0; err_r <= '0;
    end else begin
      state <= state_n;
      // Strobes land at this edge, so SWAP sees a same-cycle strobe's value
      if (line_ready) begin
        if (line_x0_valid)    x0_r    <= line_point;
        if (line_y0_valid)    y0_r    <= line_point;
        if (line_x1_valid)    x1_r    <= line_point;
        if (line_y1_valid)    y1_r    <= line_point;
        if (line_color_valid) color_r <= line_color[23:0];
      end
      // line_ready re-arms one cycle after the FSM is back in IDLE
      if (line_ready && line_trigger) line_ready <= 1'b0;
      else if (state == LE_IDLE)      line_ready <= 1'b1;

      case (state)
        LE_SWAP: begin
          steep_r <= steep_c;
          if (sx0 > sx1) begin
            wx0_r <= sx1; wy0_r <= sy1; wx1_r <= sx0; wy1_r <= sy0;
          end else begin
            wx0_r <= sx0; wy0_r <= sy0; wx1_r <= sx1; wy1_r <= sy1;
          end
        end
        LE_INIT: begin
          dx_r    <= wx1_r - wx0_r;
          dy_r    <= (wy1_r >= wy0_r) ? wy1_r - wy0_r : wy0_r - wy1_r;
          err_r   <= $signed({3'b000, dx_r_init(wx1_r, wx0_r)});
          ydown_r <= !(wy0_r < wy1_r);
          x_r     <= wx0_r;
          y_r     <= wy0_r;
        end
        LE_DRAW: begin
          if (step) begin
            x_r <= x_r + 1'b1;
            if (err_sub < 0) begin
              err_r <= err_sub + $signed({2'b00, dx_r});
              y_r   <= ydown_r ? y_r - 1'b1 : y_r + 1'b1;
            end else begin
              err_r <= err_sub;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // dx >> 1 computed from the normalised endpoints, before dx_r is loaded
  function automatic logic [COORD_W-2:0] dx_r_init(input logic [COORD_W-1:0] a, b);
    logic [COORD_W-1:0] d;
    d = a - b;
    return d[COORD_W-1:1];
  endfunction

endmodule
